// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared types and helpers for the quadrature encoder front end.
//
// Contents:
//   quad_state_t  - decoder FSM states (INIT while baselining, TRACK after)
//   ACC_W         - width of the signed detent accumulator
//   CW_SEQ        - clockwise Gray order of {a,b}, A leading
//   gray_step_t   - result of decoding one {a,b} transition
//   gray_index()  - position of a code inside CW_SEQ
//   gray_step()   - direction (-1/0/+1) and illegal flag for prev -> cur
// -----------------------------------------------------------------------------
package quad_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } quad_state_t;

  // Holds +/-STEPS_PER_DETENT (at most 4) as a signed value.
  localparam int ACC_W = 4;

  // Clockwise rotation walks this table forwards, counter-clockwise backwards.
  localparam logic [1:0] CW_SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  typedef struct packed {
    logic signed [1:0] dir;      // +1 clockwise, -1 counter-clockwise, 0 none
    logic              illegal;  // both lines changed together
  } gray_step_t;

  function automatic logic [1:0] gray_index(input logic [1:0] code);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (CW_SEQ[i] == code) begin
        idx = i[1:0];
      end
    end
    return idx;
  endfunction

  // The distance between the two table positions, modulo 4, gives the
  // transition type: 1 forward, 3 backward, 2 means a skipped state.
  function automatic gray_step_t gray_step(input logic [1:0] prev,
                                           input logic [1:0] cur);
    gray_step_t r;
    logic [1:0] delta;
    r.dir     = 2'sd0;
    r.illegal = 1'b0;
    delta     = gray_index(cur) - gray_index(prev);
    case (delta)
      2'd1:    r.dir     = 2'sd1;
      2'd3:    r.dir     = -2'sd1;
      2'd2:    r.illegal = 1'b1;
      default: r.dir     = 2'sd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Synchroniser plus stability filter for one raw encoder line.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive cycles a new level must be held (>= 2)
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   line_raw  in   raw line, asynchronous to clk
//   db        out  debounced level (resets to 0)
//   acc_pulse out  one-cycle pulse on the cycle db takes a new level
//   settled   out  sticky: the line has completed one full stable window
//                  since reset (either an accepted change or DEBOUNCE_CYCLES
//                  cycles of agreement with db)
// -----------------------------------------------------------------------------
module debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_raw,
  output logic db,
  output logic acc_pulse,
  output logic settled
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-stage synchroniser.
  logic s1_q, s2_q;

  // Change filter.
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_pulse_q, acc_pulse_d;

  // Start-up window tracking. fill_q marks when s2 first holds a real sample,
  // so the reset value of the synchroniser cannot count as a stable window.
  logic [1:0]       fill_q;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic             settled_q, settled_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      db_q         <= 1'b0;
      cnt_q        <= '0;
      acc_pulse_q  <= 1'b0;
      fill_q       <= 2'b00;
      stable_cnt_q <= '0;
      settled_q    <= 1'b0;
    end else begin
      s1_q         <= line_raw;
      s2_q         <= s1_q;
      db_q         <= db_d;
      cnt_q        <= cnt_d;
      acc_pulse_q  <= acc_pulse_d;
      fill_q       <= {fill_q[0], 1'b1};
      stable_cnt_q <= stable_cnt_d;
      settled_q    <= settled_d;
    end
  end

  always_comb begin
    db_d         = db_q;
    cnt_d        = cnt_q;
    acc_pulse_d  = 1'b0;
    stable_cnt_d = stable_cnt_q;
    settled_d    = settled_q;

    if (s2_q == db_q) begin
      // Agreement: any pending change was a glitch, drop its count.
      cnt_d = '0;
      if (fill_q[1] && !settled_q) begin
        if (stable_cnt_q == CNT_LAST) begin
          settled_d = 1'b1;
        end else begin
          stable_cnt_d = stable_cnt_q + 1'b1;
        end
      end
    end else begin
      stable_cnt_d = '0;
      if (cnt_q == CNT_LAST) begin
        db_d        = s2_q;
        cnt_d       = '0;
        acc_pulse_d = 1'b1;
        settled_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign db        = db_q;
  assign acc_pulse = acc_pulse_q;
  assign settled   = settled_q;

endmodule

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
// Rotary encoder front end: debounces the raw A/B lines, follows the Gray
// sequence and emits one cw/ccw pulse per mechanical detent.
//
// Parameters:
//   DEBOUNCE_CYCLES  - stable cycles before a line change is accepted (>= 2)
//   STEPS_PER_DETENT - Gray transitions per output pulse (1, 2 or 4)
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   enc_a    in   raw channel A, asynchronous
//   enc_b    in   raw channel B, asynchronous
//   cw       out  one-cycle pulse, clockwise detent completed
//   ccw      out  one-cycle pulse, counter-clockwise detent completed
//   err      out  one-cycle pulse, both lines changed at once
// -----------------------------------------------------------------------------
module quad_decoder
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enc_a,
  input  logic enc_b,
  output logic cw,
  output logic ccw,
  output logic err
);

  localparam logic signed [ACC_W-1:0] DETENT_POS = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] DETENT_NEG = -DETENT_POS;

  // Bit 1 is line A, bit 0 is line B, so the vectors read as {a,b}.
  logic [1:0] raw_vec;
  logic [1:0] db_vec;
  logic [1:0] acc_pulse_vec;
  logic [1:0] settled_vec;

  assign raw_vec = {enc_a, enc_b};

  for (genvar gi = 0; gi < 2; gi++) begin : gen_line
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .line_raw (raw_vec[gi]),
      .db       (db_vec[gi]),
      .acc_pulse(acc_pulse_vec[gi]),
      .settled  (settled_vec[gi])
    );
  end

  quad_state_t              state_q, state_d;
  logic [1:0]               prev_q, prev_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     cw_q, cw_d;
  logic                     ccw_q, ccw_d;
  logic                     err_q, err_d;

  gray_step_t               step;
  logic signed [ACC_W-1:0]  step_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     both_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      prev_q  <= 2'b00;
      acc_q   <= '0;
      cw_q    <= 1'b0;
      ccw_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      cw_q    <= cw_d;
      ccw_q   <= ccw_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    step     = gray_step(prev_q, db_vec);
    step_ext = {{(ACC_W-2){step.dir[1]}}, step.dir};
    acc_sum  = acc_q + step_ext;
    // Both filters accepting on the same edge is a simultaneous change.
    both_acc = &acc_pulse_vec;

    state_d = state_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    cw_d    = 1'b0;
    ccw_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      INIT: begin
        // Wait until both lines have real levels so the reset value 00
        // is never mistaken for a step towards the idle level.
        acc_d = '0;
        if (&settled_vec) begin
          prev_d  = db_vec;
          state_d = TRACK;
        end
      end
      TRACK: begin
        prev_d = db_vec;
        if (step.illegal || both_acc) begin
          err_d = 1'b1;
          acc_d = '0;
        end else if (step.dir != 2'sd0) begin
          // Opposite steps subtract, so a reversal unwinds partial
          // progress instead of producing a pulse.
          if (acc_sum == DETENT_POS) begin
            cw_d  = 1'b1;
            acc_d = '0;
          end else if (acc_sum == DETENT_NEG) begin
            ccw_d = 1'b1;
            acc_d = '0;
          end else begin
            acc_d = acc_sum;
          end
        end
      end
      default: begin
        state_d = INIT;
        acc_d   = '0;
      end
    endcase
  end

  assign cw  = cw_q;
  assign ccw = ccw_q;
  assign err = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;
  import quad_pkg::*;

  localparam int DC   = 4;
  localparam int LAT  = DC + 3;   // drive edge to pulse-visible edge
  localparam int HOLD = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n  = 1'b1;
  logic enc_a    = 1'b1;
  logic enc_b    = 1'b1;
  logic cw, ccw, err;
  logic reset2_n = 1'b1;
  logic enc2_a   = 1'b1;
  logic enc2_b   = 1'b1;
  logic cw2, ccw2, err2;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         c;
    logic [2:0] k;   // {cw, ccw, err}
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t exp2_q[$];
  ev_t obs2_q[$];
  ev_t mon_ev;

  quad_decoder #(.DEBOUNCE_CYCLES(DC), .STEPS_PER_DETENT(4)) dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
    .cw(cw), .ccw(ccw), .err(err)
  );

  quad_decoder #(.DEBOUNCE_CYCLES(DC), .STEPS_PER_DETENT(1)) dut2 (
    .clk(clk), .reset_n(reset2_n), .enc_a(enc2_a), .enc_b(enc2_b),
    .cw(cw2), .ccw(ccw2), .err(err2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ({cw, ccw, err} != 3'b000) begin
      mon_ev.c = cyc;
      mon_ev.k = {cw, ccw, err};
      obs_q.push_back(mon_ev);
    end
    if ({cw2, ccw2, err2} != 3'b000) begin
      mon_ev.c = cyc;
      mon_ev.k = {cw2, ccw2, err2};
      obs2_q.push_back(mon_ev);
    end
  end

  task automatic drive(input bit sel, input logic a, input logic b, output int dcyc);
    @(posedge clk);
    #1;
    if (sel) begin
      enc2_a = a;
      enc2_b = b;
    end else begin
      enc_a = a;
      enc_b = b;
    end
    dcyc = cyc;
    repeat (HOLD) @(posedge clk);
  endtask

  task automatic test_reset();
    ev_t e, o;
    #2;
    reset_n  = 1'b0;
    reset2_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({cw, ccw, err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: actual %b, required 000", {cw, ccw, err});
    end
    tests++;
    if (dut.state_q !== INIT) begin
      fails++;
      $display("FAIL reset_state: actual %0d, required INIT", dut.state_q);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    reset2_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    tests++;
    if (dut.state_q !== TRACK) begin
      fails++;
      $display("FAIL baseline_state: actual %0d, required TRACK", dut.state_q);
    end
    tests++;
    if (dut.acc_q !== 4'sd0) begin
      fails++;
      $display("FAIL baseline_acc: actual %0d, required 0", dut.acc_q);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL baseline missing: actual none, required %b at %0d", e.k, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.k !== e.k || o.c !== e.c) begin
          fails++;
          $display("FAIL baseline pulse: actual %b at %0d, required %b at %0d", o.k, o.c, e.k, e.c);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL baseline extra: actual %0d pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_cw_detent();
    ev_t e, o;
    int d;
    drive(0, 1'b0, 1'b1, d);
    drive(0, 1'b0, 1'b0, d);
    drive(0, 1'b1, 1'b0, d);
    drive(0, 1'b1, 1'b1, d);
    e.c = d + LAT; e.k = 3'b100; exp_q.push_back(e);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL cw_detent missing: actual none, required %b at %0d", e.k, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.k !== e.k || o.c !== e.c) begin
          fails++;
          $display("FAIL cw_detent pulse: actual %b at %0d, required %b at %0d", o.k, o.c, e.k, e.c);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL cw_detent extra: actual %0d pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_ccw_detent();
    ev_t e, o;
    int d;
    drive(0, 1'b1, 1'b0, d);
    drive(0, 1'b0, 1'b0, d);
    drive(0, 1'b0, 1'b1, d);
    drive(0, 1'b1, 1'b1, d);
    e.c = d + LAT; e.k = 3'b010; exp_q.push_back(e);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL ccw_detent missing: actual none, required %b at %0d", e.k, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.k !== e.k || o.c !== e.c) begin
          fails++;
          $display("FAIL ccw_detent pulse: actual %b at %0d, required %b at %0d", o.k, o.c, e.k, e.c);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL ccw_detent extra: actual %0d pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reversal();
    int d;
    drive(0, 1'b0, 1'b1, d);
    drive(0, 1'b0, 1'b0, d);
    tests++;
    if (dut.acc_q !== 4'sd2) begin
      fails++;
      $display("FAIL reversal_mid_acc: actual %0d, required 2", dut.acc_q);
    end
    drive(0, 1'b0, 1'b1, d);
    drive(0, 1'b1, 1'b1, d);
    tests++;
    if (dut.acc_q !== 4'sd0) begin
      fails++;
      $display("FAIL reversal_end_acc: actual %0d, required 0", dut.acc_q);
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL reversal extra: actual %0d pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_glitch_illegal();
    ev_t e, o;
    int d;
    @(posedge clk);
    #1 enc_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 enc_a = 1'b1;
    repeat (HOLD) @(posedge clk);
    tests++;
    if (obs_q.size() != 0 || dut.acc_q !== 4'sd0) begin
      fails++;
      $display("FAIL glitch: actual %0d pulses acc %0d, required 0 pulses acc 0", obs_q.size(), dut.acc_q);
      obs_q.delete();
    end
    drive(0, 1'b0, 1'b0, d);
    e.c = d + LAT; e.k = 3'b001; exp_q.push_back(e);
    drive(0, 1'b1, 1'b1, d);
    e.c = d + LAT; e.k = 3'b001; exp_q.push_back(e);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL illegal missing: actual none, required %b at %0d", e.k, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.k !== e.k || o.c !== e.c) begin
          fails++;
          $display("FAIL illegal pulse: actual %b at %0d, required %b at %0d", o.k, o.c, e.k, e.c);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL illegal extra: actual %0d pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_detent();
    ev_t e, o;
    int d;
    drive(0, 1'b0, 1'b1, d);
    drive(0, 1'b0, 1'b0, d);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if (dut.acc_q !== 4'sd0 || dut.state_q !== INIT) begin
      fails++;
      $display("FAIL midreset_clear: actual acc %0d state %0d, required acc 0 INIT", dut.acc_q, dut.state_q);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (15) @(posedge clk);
    tests++;
    if (dut.state_q !== TRACK) begin
      fails++;
      $display("FAIL midreset_rebase: actual %0d, required TRACK", dut.state_q);
    end
    drive(0, 1'b1, 1'b0, d);
    drive(0, 1'b1, 1'b1, d);
    tests++;
    if (dut.acc_q !== 4'sd2 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL midreset_nopulse: actual acc %0d pulses %0d, required acc 2 pulses 0", dut.acc_q, obs_q.size());
      obs_q.delete();
    end
    // Two more forward steps complete a detent counted from the new baseline.
    drive(0, 1'b0, 1'b1, d);
    drive(0, 1'b0, 1'b0, d);
    e.c = d + LAT; e.k = 3'b100; exp_q.push_back(e);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL midreset missing: actual none, required %b at %0d", e.k, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.k !== e.k || o.c !== e.c) begin
          fails++;
          $display("FAIL midreset pulse: actual %b at %0d, required %b at %0d", o.k, o.c, e.k, e.c);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL midreset extra: actual %0d pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_divisor();
    ev_t e, o;
    int d;
    tests++;
    if (obs2_q.size() != 0) begin
      fails++;
      $display("FAIL divisor_idle: actual %0d pulses, required 0", obs2_q.size());
      obs2_q.delete();
    end
    drive(1, 1'b0, 1'b1, d);
    e.c = d + LAT; e.k = 3'b100; exp2_q.push_back(e);
    drive(1, 1'b0, 1'b0, d);
    e.c = d + LAT; e.k = 3'b100; exp2_q.push_back(e);
    drive(1, 1'b1, 1'b0, d);
    e.c = d + LAT; e.k = 3'b100; exp2_q.push_back(e);
    drive(1, 1'b1, 1'b1, d);
    e.c = d + LAT; e.k = 3'b100; exp2_q.push_back(e);
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      tests++;
      if (obs2_q.size() == 0) begin
        fails++;
        $display("FAIL divisor missing: actual none, required %b at %0d", e.k, e.c);
      end else begin
        o = obs2_q.pop_front();
        if (o.k !== e.k || o.c !== e.c) begin
          fails++;
          $display("FAIL divisor pulse: actual %b at %0d, required %b at %0d", o.k, o.c, e.k, e.c);
        end
      end
    end
    tests++;
    if (obs2_q.size() != 0) begin
      fails++;
      $display("FAIL divisor extra: actual %0d pulses, required 0", obs2_q.size());
      obs2_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cw_detent();
    test_ccw_detent();
    test_reversal();
    test_glitch_illegal();
    test_reset_mid_detent();
    test_divisor();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
